// File: rtl/exec_ctrl.sv
// exec_ctrl: multicycle execute-stage controller sequencing RF read, ALU, data memory and write-back.
// Latency: ALU op / LOAD = 4 cycles accept-to-ready with immediate done/ack, STORE = 3, NOP retires next cycle.
// Backpressure: instr_ready is high only in IDLE; a per-instruction watchdog aborts EXEC/MEM waits with err.
// Ports: instr_valid/instr_ready + decoded fields from decode; rf_rd_* / rf_wr_* to the register file;
//        alu_* handshake (alu_en .. alu_done); mem_* handshake (mem_req .. mem_ack); retire/err status pulses.
module exec_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [4:0]    opcode,
  input  logic [4:0]    rsrc1,
  input  logic [4:0]    rsrc2,
  input  logic [4:0]    rdst,
  output logic          rf_rd_en,
  output logic [4:0]    rf_rd_addr1,
  output logic [4:0]    rf_rd_addr2,
  input  logic [DW-1:0] rf_rd_data1,
  input  logic [DW-1:0] rf_rd_data2,
  output logic          alu_en,
  output logic [4:0]    alu_op,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic          alu_done,
  input  logic [DW-1:0] alu_result,
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          rf_wr_en,
  output logic [4:0]    rf_wr_addr,
  output logic [DW-1:0] rf_wr_data,
  output logic          retire,
  output logic          err
);

  localparam logic [4:0] OP_NOP   = 5'h00;
  localparam logic [4:0] OP_LOAD  = 5'h10;
  localparam logic [4:0] OP_STORE = 5'h11;

  // Counter only needs to reach TIMEOUT-1; it saturates there.
  localparam int            CW      = $clog2(TIMEOUT);
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  state_t        state, state_nxt;
  logic [4:0]    op_q, rs1_q, rs2_q, rd_q;
  logic [DW-1:0] a_q, b_q, res_q;
  logic [CW-1:0] wd_cnt;
  logic          nop_pend;   // NOP accepted last cycle: retire now
  logic          is_mem, is_store, wd_expired;

  assign is_store   = (op_q == OP_STORE);
  assign is_mem     = (op_q == OP_LOAD) || is_store;
  assign wd_expired = (wd_cnt == WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    rf_rd_en    = 1'b0;
    rf_rd_addr1 = '0;
    rf_rd_addr2 = '0;
    alu_en      = 1'b0;
    alu_op      = '0;
    alu_a       = '0;
    alu_b       = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    rf_wr_en    = 1'b0;
    rf_wr_addr  = '0;
    rf_wr_data  = '0;
    retire      = nop_pend;
    err         = 1'b0;
    case (state)
      S_IDLE: begin
        // Gated by rst_n so every output reads 0 while reset is asserted.
        instr_ready = rst_n;
        if (instr_valid && rst_n && (opcode != OP_NOP)) state_nxt = S_READ;
      end
      S_READ: begin
        rf_rd_en    = 1'b1;
        rf_rd_addr1 = rs1_q;
        rf_rd_addr2 = rs2_q;
        state_nxt   = is_mem ? S_MEM : S_EXEC;
      end
      S_EXEC: begin
        alu_en = 1'b1;
        alu_op = op_q;
        alu_a  = a_q;
        alu_b  = b_q;
        // Completion takes priority over an expiring watchdog.
        if (alu_done) begin
          state_nxt = S_WB;
        end else if (wd_expired) begin
          err       = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_MEM: begin
        mem_req   = 1'b1;
        mem_we    = is_store;
        mem_addr  = a_q;
        mem_wdata = b_q;
        if (mem_ack) begin
          if (is_store) begin
            retire    = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_WB;
          end
        end else if (wd_expired) begin
          err       = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_WB: begin
        // r0 is hardwired to zero: no write strobe, address or data for it.
        if (rd_q != 5'd0) begin
          rf_wr_en   = 1'b1;
          rf_wr_addr = rd_q;
          rf_wr_data = res_q;
        end
        retire    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      wd_cnt   <= '0;
      nop_pend <= 1'b0;
    end else begin
      nop_pend <= 1'b0;
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            op_q     <= opcode;
            rs1_q    <= rsrc1;
            rs2_q    <= rsrc2;
            rd_q     <= rdst;
            nop_pend <= (opcode == OP_NOP);
          end
        end
        S_READ: begin
          a_q    <= rf_rd_data1;
          b_q    <= rf_rd_data2;
          wd_cnt <= '0;
        end
        S_EXEC: begin
          if (alu_done)         res_q  <= alu_result;
          else if (!wd_expired) wd_cnt <= wd_cnt + 1'b1;
        end
        S_MEM: begin
          if (mem_ack)          res_q  <= mem_rdata;
          else if (!wd_expired) wd_cnt <= wd_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_ctrl.sv
// tb_exec_ctrl: self-checking bench for exec_ctrl acting as decode, register file, ALU and data memory.
// Directed vector table, hand-written reset/NOP sequences, then randomized instructions vs. an ISA-level model.
module tb_exec_ctrl;
  localparam int TIMEOUT = 16;
  localparam int DW      = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          instr_valid, instr_ready;
  logic [4:0]    opcode, rsrc1, rsrc2, rdst;
  logic          rf_rd_en;
  logic [4:0]    rf_rd_addr1, rf_rd_addr2;
  logic [DW-1:0] rf_rd_data1, rf_rd_data2;
  logic          alu_en, alu_done;
  logic [4:0]    alu_op;
  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic          mem_req, mem_we, mem_ack;
  logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
  logic          rf_wr_en;
  logic [4:0]    rf_wr_addr;
  logic [DW-1:0] rf_wr_data;
  logic          retire, err;

  always #5 clk = ~clk;

  exec_ctrl #(.TIMEOUT(TIMEOUT), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .rsrc1(rsrc1), .rsrc2(rsrc2), .rdst(rdst),
    .rf_rd_en(rf_rd_en), .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
    .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
    .alu_en(alu_en), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .retire(retire), .err(err)
  );

  // Architectural state: register file and sparse data memory.
  logic [31:0] rf [32];
  logic [31:0] mem [logic [31:0]];

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct packed {
    logic        err;
    int          cyc;
    int          wr;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    int          mreq;
    logic [31:0] maddr;
    logic        mwe;
    logic [31:0] mwdata;
  } exp_t;

  typedef struct packed {
    logic [4:0] op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    int         dly;
    exp_t       e;
  } vec_t;

  typedef struct packed {
    logic        rdy;
    logic        err;
    logic        bad;
    int          cyc;
    int          nret;
    int          nerr;
    int          wr;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    int          mreq;
    logic [31:0] maddr;
    logic        mwe;
    logic [31:0] mwdata;
  } obs_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] rf_rd(input logic [4:0] i);
    return (i == 5'd0) ? 32'd0 : rf[i];
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : ((a * 32'h9E3779B1) ^ 32'h5A5A0F0F);
  endfunction

  // Bench ALU: add, with the result tagged by the op so a wrong op is visible.
  function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] k;
    k = 32'(op) - 32'd1;
    return (a + b) ^ (k << 8);
  endfunction

  function automatic logic any_out();
    return |{rf_rd_en, rf_rd_addr1, rf_rd_addr2, alu_en, alu_op, alu_a, alu_b,
             mem_req, mem_we, mem_addr, mem_wdata, rf_wr_en, rf_wr_addr, rf_wr_data, retire, err};
  endfunction

  function automatic vec_t mk(input logic [4:0] op, rs1, rs2, rd, input int dly,
                              input logic er, input int cyc, input int wr, input logic [4:0] wa,
                              input logic [31:0] wd, input int mreq, input logic [31:0] ma,
                              input logic mwe, input logic [31:0] mwd);
    vec_t v;
    v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.dly = dly;
    v.e.err = er; v.e.cyc = cyc; v.e.wr = wr; v.e.waddr = wa; v.e.wdata = wd;
    v.e.mreq = mreq; v.e.maddr = ma; v.e.mwe = mwe; v.e.mwdata = mwd;
    return v;
  endfunction

  // ISA-level reference: outcome, completion cycle and side effects from current state.
  // dly = wait cycles before done/ack; the watchdog allows wait indices 0..TIMEOUT-1.
  function automatic exp_t model(input logic [4:0] op, rs1, rs2, rd, input int dly);
    exp_t        e;
    logic [31:0] a, b;
    logic        to;
    a  = rf_rd(rs1);
    b  = rf_rd(rs2);
    to = (dly >= TIMEOUT);
    e  = '0;
    if (op == 5'h00) begin
      e.cyc = 1;
    end else begin
      e.err = to;
      if (op == 5'h10 || op == 5'h11) begin
        e.mreq   = to ? TIMEOUT : dly + 1;
        e.maddr  = a;
        e.mwe    = (op == 5'h11);
        e.mwdata = b;
      end
      if (op == 5'h11) e.cyc = to ? TIMEOUT + 1 : dly + 2;
      else             e.cyc = to ? TIMEOUT + 1 : dly + 3;
      if (op != 5'h11 && !to && rd != 5'd0) begin
        e.wr    = 1;
        e.waddr = rd;
        e.wdata = (op == 5'h10) ? mem_rd(a) : alu_f(op, a, b);
      end
    end
    return e;
  endfunction

  task automatic run_instr(input logic [4:0] op, rs1, rs2, rd, input int dly, output obs_t o);
    int          wcnt;
    logic [31:0] f_a, f_b;
    logic [4:0]  f_op;
    o    = '0;
    wcnt = 0;
    f_a  = '0; f_b = '0; f_op = '0;
    @(negedge clk);
    alu_done = 1'b0; mem_ack = 1'b0;
    instr_valid = 1'b1; opcode = op; rsrc1 = rs1; rsrc2 = rs2; rdst = rd;
    #1;
    o.rdy = instr_ready;
    if (retire || err || rf_wr_en || alu_en || mem_req) o.bad = 1'b1;
    for (int c = 1; c <= TIMEOUT + 8; c++) begin
      @(negedge clk);
      if (instr_ready) begin
        instr_valid = 1'b0;
      end else begin
        // Garbage on the decode side while busy must be ignored.
        instr_valid = 1'($urandom);
        opcode = 5'($urandom); rsrc1 = 5'($urandom); rsrc2 = 5'($urandom); rdst = 5'($urandom);
      end
      rf_rd_data1 = rf_rd(rf_rd_addr1);
      rf_rd_data2 = rf_rd(rf_rd_addr2);
      if (alu_en) begin
        alu_done = (wcnt == dly); alu_result = alu_f(alu_op, alu_a, alu_b);
      end else begin
        alu_done = ($urandom_range(0, 4) == 0); alu_result = $urandom;
      end
      if (mem_req) begin
        mem_ack = (wcnt == dly); mem_rdata = mem_rd(mem_addr);
      end else begin
        mem_ack = ($urandom_range(0, 4) == 0); mem_rdata = $urandom;
      end
      #1;
      if (alu_en || mem_req) wcnt++;
      if (retire) o.nret++;
      if (err) begin o.nerr++; o.err = 1'b1; end
      if (instr_ready && !retire && !err) o.bad = 1'b1;
      if (!mem_req && (mem_we || mem_addr != 0 || mem_wdata != 0)) o.bad = 1'b1;
      if (!alu_en && (alu_op != 0 || alu_a != 0 || alu_b != 0)) o.bad = 1'b1;
      if (!rf_rd_en && (rf_rd_addr1 != 0 || rf_rd_addr2 != 0)) o.bad = 1'b1;
      if (!rf_wr_en && (rf_wr_addr != 0 || rf_wr_data != 0)) o.bad = 1'b1;
      if (rf_wr_en) begin
        o.wr++; o.waddr = rf_wr_addr; o.wdata = rf_wr_data;
        if (rf_wr_addr != 5'd0) rf[rf_wr_addr] = rf_wr_data;
      end
      if (mem_req) begin
        o.mreq++;
        if (o.mreq == 1) begin
          o.maddr = mem_addr; o.mwe = mem_we; o.mwdata = mem_wdata;
        end else if (o.maddr != mem_addr || o.mwe != mem_we || o.mwdata != mem_wdata) begin
          o.bad = 1'b1;
        end
        if (mem_we && mem_ack) mem[mem_addr] = mem_wdata;
      end
      if (alu_en) begin
        if (f_op == 5'd0) begin
          f_op = alu_op; f_a = alu_a; f_b = alu_b;
        end else if (f_op != alu_op || f_a != alu_a || f_b != alu_b) begin
          o.bad = 1'b1;
        end
      end
      if (retire || err) begin
        o.cyc = c;
        break;
      end
    end
  endtask

  task automatic compare(input string tag, input obs_t o, input exp_t e);
    chk({tag, " ready_at_issue"}, 32'(o.rdy), 32'd1);
    chk({tag, " done_cycle"}, o.cyc, e.cyc);
    chk({tag, " err_outcome"}, 32'(o.err), 32'(e.err));
    chk({tag, " pulse_count"}, o.nret + o.nerr, 32'd1);
    chk({tag, " wr_count"}, o.wr, e.wr);
    if (e.wr != 0) begin
      chk({tag, " wr_addr"}, 32'(o.waddr), 32'(e.waddr));
      chk({tag, " wr_data"}, o.wdata, e.wdata);
    end
    chk({tag, " mem_cycles"}, o.mreq, e.mreq);
    if (e.mreq != 0) begin
      chk({tag, " mem_addr"}, o.maddr, e.maddr);
      chk({tag, " mem_we"}, 32'(o.mwe), 32'(e.mwe));
      chk({tag, " mem_wdata"}, o.mwdata, e.mwdata);
    end
    chk({tag, " protocol"}, 32'(o.bad), 32'd0);
  endtask

  vec_t tbl [10];

  initial begin
    obs_t        o;
    exp_t        e;
    logic [4:0]  op, r1, r2, rd;
    int          dly, sel, cnt;
    logic [3:0]  rets;

    instr_valid = 1'b0; opcode = '0; rsrc1 = '0; rsrc2 = '0; rdst = '0;
    rf_rd_data1 = '0; rf_rd_data2 = '0; alu_done = 1'b0; alu_result = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    rf[1] = 32'd5; rf[2] = 32'd7; rf[4] = 32'h100; rf[7] = 32'h20; rf[8] = 32'h55;
    mem[32'h100] = 32'hDEADBEEF;

    tbl[0] = mk(5'h01, 5'd1, 5'd2, 5'd3,  0,           1'b0, 3,           1, 5'd3,  32'd12,        0,       32'h0,   1'b0, 32'h0);
    tbl[1] = mk(5'h10, 5'd4, 5'd0, 5'd6,  3,           1'b0, 6,           1, 5'd6,  32'hDEADBEEF,  4,       32'h100, 1'b0, 32'h0);
    tbl[2] = mk(5'h11, 5'd7, 5'd8, 5'd9,  0,           1'b0, 2,           0, 5'd0,  32'h0,         1,       32'h20,  1'b1, 32'h55);
    tbl[3] = mk(5'h02, 5'd1, 5'd2, 5'd10, TIMEOUT,     1'b1, TIMEOUT + 1, 0, 5'd0,  32'h0,         0,       32'h0,   1'b0, 32'h0);
    tbl[4] = mk(5'h02, 5'd1, 5'd2, 5'd10, TIMEOUT - 1, 1'b0, TIMEOUT + 2, 1, 5'd10, 32'h10C,       0,       32'h0,   1'b0, 32'h0);
    tbl[5] = mk(5'h10, 5'd4, 5'd0, 5'd12, TIMEOUT,     1'b1, TIMEOUT + 1, 0, 5'd0,  32'h0,         TIMEOUT, 32'h100, 1'b0, 32'h0);
    tbl[6] = mk(5'h11, 5'd7, 5'd8, 5'd9,  TIMEOUT - 1, 1'b0, TIMEOUT + 1, 0, 5'd0,  32'h0,         TIMEOUT, 32'h20,  1'b1, 32'h55);
    tbl[7] = mk(5'h01, 5'd3, 5'd1, 5'd0,  0,           1'b0, 3,           0, 5'd0,  32'h0,         0,       32'h0,   1'b0, 32'h0);
    tbl[8] = mk(5'h00, 5'd1, 5'd2, 5'd5,  0,           1'b0, 1,           0, 5'd0,  32'h0,         0,       32'h0,   1'b0, 32'h0);
    tbl[9] = mk(5'h03, 5'd3, 5'd6, 5'd11, 2,           1'b0, 5,           1, 5'd11, 32'hDEADBCFB,  0,       32'h0,   1'b0, 32'h0);

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("reset outputs_zero", 32'(any_out()), 32'd0);
    chk("reset ready_low", 32'(instr_ready), 32'd0);
    rst_n = 1'b1; #1;
    chk("reset ready_after_release", 32'(instr_ready), 32'd1);
    chk("reset outputs_after_release", 32'(any_out()), 32'd0);

    // Directed vectors.
    for (int i = 0; i < 10; i++) begin
      run_instr(tbl[i].op, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].dly, o);
      compare($sformatf("vec%0d", i), o, tbl[i].e);
    end

    // Three back-to-back NOPs: accepted every cycle, three consecutive retires, no write.
    @(negedge clk);
    alu_done = 1'b0; mem_ack = 1'b0;
    instr_valid = 1'b1; opcode = 5'h00; rsrc1 = 5'd1; rsrc2 = 5'd2; rdst = 5'd5;
    rets = '0; cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      rets[k] = retire;
      if (rf_wr_en || err || !instr_ready) cnt++;
      if (k == 2) instr_valid = 1'b0;
    end
    chk("nop3 retire_pattern", 32'(rets), 32'h7);
    chk("nop3 no_write_err_ready", cnt, 0);

    // Reset mid-EXEC: everything drops at once, nothing completes afterwards.
    @(negedge clk);
    instr_valid = 1'b1; opcode = 5'h01; rsrc1 = 5'd1; rsrc2 = 5'd2; rdst = 5'd3;
    @(negedge clk); instr_valid = 1'b0;
    rf_rd_data1 = rf_rd(rf_rd_addr1); rf_rd_data2 = rf_rd(rf_rd_addr2);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mid in_exec", 32'(alu_en), 32'd1);
    rst_n = 1'b0; #1;
    chk("rst_mid outputs_zero", 32'(any_out()), 32'd0);
    chk("rst_mid ready_low", 32'(instr_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; #1;
    chk("rst_mid ready_after", 32'(instr_ready), 32'd1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      alu_done = 1'($urandom); mem_ack = 1'($urandom);
      #1;
      if (retire || err || rf_wr_en || alu_en || mem_req || !instr_ready) cnt++;
    end
    chk("rst_mid quiet_after", cnt, 0);
    alu_done = 1'b0; mem_ack = 1'b0;

    // Randomized instructions against the reference model.
    for (int i = 1; i < 32; i++) rf[i] = $urandom;
    for (int n = 0; n < 200; n++) begin
      sel = $urandom_range(0, 7);
      if (sel == 0)      op = 5'h00;
      else if (sel <= 2) op = 5'h10;
      else if (sel <= 4) op = 5'h11;
      else begin
        op = 5'($urandom_range(1, 29));
        if (op >= 5'h10) op = op + 5'd2;
      end
      r1 = 5'($urandom); r2 = 5'($urandom); rd = 5'($urandom);
      sel = $urandom_range(0, 9);
      if (sel <= 6)      dly = $urandom_range(0, 3);
      else if (sel == 7) dly = $urandom_range(4, TIMEOUT - 2);
      else if (sel == 8) dly = TIMEOUT - 1;
      else               dly = TIMEOUT + $urandom_range(0, 3);
      e = model(op, r1, r2, rd, dly);
      run_instr(op, r1, r2, rd, dly, o);
      compare($sformatf("rnd%0d op=%0h dly=%0d", n, op, dly), o, e);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
